vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator and pixel pipeline: the next generation of the fixed 640x480 controller.
- Produces hsync/vsync with selectable polarity, data-enable, a pixel request that leads the display by a programmable number of cycles, and a border colour. Also produces frame/line start strobes and an enable that only starts or stops on frame boundaries.
- Sits between the pixel clock domain and the frame source (ROM, line buffer, sobel output) and drives the VGA DAC pins.

---
 rtl/vga_pkg.sv | 76 +++++++
 rtl/vga_axis_cnt.sv | 73 +++++++
 rtl/vga_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, constants and configuration helpers for the VGA timing generator.
package vga_pkg;

  // Width of every position counter and every region compare.
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = 1 << CNT_W;

  // Legal range of the request lead.
  localparam int LEAD_MIN = 1;
  localparam int LEAD_MAX = 4;

  // Where an axis position falls along its line/frame.
  typedef enum logic [2:0] {
    SYNC,
    BACK,
    BORDER_LO,
    ACTIVE,
    BORDER_HI,
    FRONT
  } region_e;

  // Enable FSM: IDLE holds counters, RUN counts, DRAIN finishes the frame then stops.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } run_state_e;

  // Segment lengths of one axis, in the order they occur.
  typedef struct packed {
    logic [CNT_W-1:0] sync;
    logic [CNT_W-1:0] back;
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] valid;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] front;
  } axis_mode_t;

  typedef struct packed {
    axis_mode_t h;
    axis_mode_t v;
    logic       hs_pol;
    logic       vs_pol;
  } vga_mode_t;

  // 640x480@60, 25.175 MHz, with an 8-pixel/8-line border carved from the porches.
  localparam vga_mode_t MODE_640X480_60 = '{
    h: '{sync: 12'd96,  back: 12'd40, lo: 12'd8, valid: 12'd640, hi: 12'd8, front: 12'd8},
    v: '{sync: 12'd2,   back: 12'd25, lo: 12'd8, valid: 12'd480, hi: 12'd8, front: 12'd2},
    hs_pol: 1'b0,
    vs_pol: 1'b0
  };

  // 800x600@60, 40 MHz, no border.
  localparam vga_mode_t MODE_800X600_60 = '{
    h: '{sync: 12'd128, back: 12'd88, lo: 12'd0, valid: 12'd800, hi: 12'd0, front: 12'd40},
    v: '{sync: 12'd4,   back: 12'd23, lo: 12'd0, valid: 12'd600, hi: 12'd0, front: 12'd1},
    hs_pol: 1'b1,
    vs_pol: 1'b1
  };

  // Total length of one axis of a mode.
  function automatic int axis_total(axis_mode_t m);
    return int'(m.sync) + int'(m.back) + int'(m.lo) + int'(m.valid) + int'(m.hi) + int'(m.front);
  endfunction

  // A configuration is usable when both totals fit the counters, the lead is in range
  // and the lead window never reaches back into the previous line.
  function automatic bit vga_cfg_ok(int h_total, int v_total, int req_lead, int h_act_start);
    return (h_total >= 1) && (h_total <= CNT_MAX) &&
           (v_total >= 1) && (v_total <= CNT_MAX) &&
           (req_lead >= LEAD_MIN) && (req_lead <= LEAD_MAX) &&
           (req_lead < h_act_start);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with wrap, region decode and lead-window decode.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int SYNC_LEN  = 96,
  parameter int BACK_LEN  = 40,
  parameter int LO_LEN    = 8,
  parameter int VALID_LEN = 640,
  parameter int HI_LEN    = 8,
  parameter int FRONT_LEN = 8,
  parameter int LEAD      = 0
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             at_end,
  output logic             in_sync,
  output logic             in_active,
  output logic             in_border,
  output logic             lead_active,
  output logic [CNT_W-1:0] lead_pos
);

  localparam int TOTAL = SYNC_LEN + BACK_LEN + LO_LEN + VALID_LEN + HI_LEN + FRONT_LEN;

  // Segment end points; each region is [previous end, this end).
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] BACK_END  = CNT_W'(SYNC_LEN + BACK_LEN);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC_LEN + BACK_LEN + LO_LEN);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC_LEN + BACK_LEN + LO_LEN + VALID_LEN);
  localparam logic [CNT_W-1:0] HI_END    = CNT_W'(SYNC_LEN + BACK_LEN + LO_LEN + VALID_LEN + HI_LEN);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LEAD_C    = CNT_W'(LEAD);

  region_e          region;
  logic [CNT_W-1:0] lead_sum;

  assign at_end = (cnt == LAST);

  // Position counter: advances on step, wraps to zero after the last position.
  always_ff @(posedge vga_clk) begin
    if (sys_rst)
      cnt <= '0;
    else if (step)
      cnt <= at_end ? '0 : cnt + CNT_W'(1);
  end

  // Region decode of the current position.
  always_comb begin
    if (cnt < SYNC_END)       region = SYNC;
    else if (cnt < BACK_END)  region = BACK;
    else if (cnt < ACT_START) region = BORDER_LO;
    else if (cnt < ACT_END)   region = ACTIVE;
    else if (cnt < HI_END)    region = BORDER_HI;
    else                      region = FRONT;
  end

  assign in_sync   = (region == SYNC);
  assign in_active = (region == ACTIVE);
  // Border span covers the active window as well; the top level masks it with de.
  assign in_border = (region == BORDER_LO) || (region == ACTIVE) || (region == BORDER_HI);

  // Lead window: is the position LEAD steps ahead inside the active segment?
  // Near the end of the axis the sum stays past ACT_END (or wraps below ACT_START),
  // so a request never spills onto the next line.
  always_comb begin
    lead_sum    = cnt + LEAD_C;
    lead_active = (lead_sum >= ACT_START) && (lead_sum < ACT_END);
    lead_pos    = lead_sum - ACT_START;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: sync/de/border generation, lead-time pixel requests and
// a frame-aligned run enable. All outputs are registered from the previous
// cycle's counter position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 40,
  parameter int          H_LEFT       = 8,
  parameter int          H_VALID      = 640,
  parameter int          H_RIGHT      = 8,
  parameter int          H_FRONT      = 8,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 25,
  parameter int          V_TOP        = 8,
  parameter int          V_VALID      = 480,
  parameter int          V_BOTTOM     = 8,
  parameter int          V_FRONT      = 2,
  parameter int          DATA_W       = 16,
  parameter int          REQ_LEAD     = 1,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned BORDER_COLOR = 0
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start,
  output logic              running
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK + H_LEFT;

  localparam logic [DATA_W-1:0] BORDER = DATA_W'(BORDER_COLOR);

  if (!vga_cfg_ok(H_TOTAL, V_TOTAL, REQ_LEAD, HA)) begin : g_cfg_err
    $error("vga_timing_gen: illegal timing configuration");
  end

  run_state_e       state_q, state_d;
  logic             live;
  logic             frame_end;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_end, v_end;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             h_brd, v_brd;
  logic             h_lead, v_lead;
  logic [CNT_W-1:0] h_lead_pos, v_lead_pos;

  logic             de_n, req_n, brd_n;

  // ---------------------------------------------------------------------------
  // Axis counters: H steps every live cycle, V steps when H wraps.
  // ---------------------------------------------------------------------------
  vga_axis_cnt #(
    .SYNC_LEN (H_SYNC),
    .BACK_LEN (H_BACK),
    .LO_LEN   (H_LEFT),
    .VALID_LEN(H_VALID),
    .HI_LEN   (H_RIGHT),
    .FRONT_LEN(H_FRONT),
    .LEAD     (REQ_LEAD)
  ) u_h (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .step       (live),
    .cnt        (h_cnt),
    .at_end     (h_end),
    .in_sync    (h_sync),
    .in_active  (h_act),
    .in_border  (h_brd),
    .lead_active(h_lead),
    .lead_pos   (h_lead_pos)
  );

  vga_axis_cnt #(
    .SYNC_LEN (V_SYNC),
    .BACK_LEN (V_BACK),
    .LO_LEN   (V_TOP),
    .VALID_LEN(V_VALID),
    .HI_LEN   (V_BOTTOM),
    .FRONT_LEN(V_FRONT),
    .LEAD     (0)
  ) u_v (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .step       (live & h_end),
    .cnt        (v_cnt),
    .at_end     (v_end),
    .in_sync    (v_sync),
    .in_active  (v_act),
    .in_border  (v_brd),
    .lead_active(v_lead),
    .lead_pos   (v_lead_pos)
  );

  assign frame_end = h_end & v_end;

  // ---------------------------------------------------------------------------
  // Enable FSM: start immediately from idle, stop only at the end of a frame.
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: a drop of en arms a stop that takes effect at the frame wrap;
  // en returning before the wrap cancels it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (frame_end) state_d = ST_IDLE;
        else if (en)   state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counters advance and outputs follow them in RUN and DRAIN.
  always_comb begin
    live = (state_q != ST_IDLE);
  end

  assign running = live;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  assign de_n  = h_act & v_act;
  assign req_n = h_lead & v_lead;
  assign brd_n = h_brd & v_brd;

  // Output registers. The counter position this cycle becomes the output position
  // next cycle. rgb is loaded from pix_data on the same edge that raises de for that
  // column, which is the edge ending cycle t+REQ_LEAD-1 for a request issued at t,
  // so the source has REQ_LEAD-1 cycles of latency (zero for REQ_LEAD=1).
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !live) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_req     <= 1'b0;
      pix_x       <= '1;
      pix_y       <= '1;
      rgb         <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hsync       <= h_sync ? HS_POL : ~HS_POL;
      vsync       <= v_sync ? VS_POL : ~VS_POL;
      de          <= de_n;
      pix_req     <= req_n;
      pix_x       <= req_n ? h_lead_pos : '1;
      pix_y       <= req_n ? v_lead_pos : '1;
      rgb         <= de_n ? pix_data : (brd_n ? BORDER : '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a tiny inverted-polarity mode
// checked position by position, and a small REQ_LEAD=3 mode with a latent pixel
// source, frame-aligned stop/start and mid-line reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: default timing, visible border colour
  logic        rst_a, en_a, hs_a, vs_a, de_a, req_a, fs_a, ls_a, run_a;
  logic [11:0] px_a, py_a;
  logic [15:0] pd_a, rgb_a;
  // DUT B: tiny mode, active-low syncs
  logic        rst_b, en_b, hs_b, vs_b, de_b, req_b, fs_b, ls_b, run_b;
  logic [11:0] px_b, py_b;
  logic [15:0] pd_b, rgb_b;
  // DUT C: small mode, REQ_LEAD=3
  logic        rst_c, en_c, hs_c, vs_c, de_c, req_c, fs_c, ls_c, run_c;
  logic [11:0] px_c, py_c;
  logic [15:0] pd_c, rgb_c;
  logic [15:0] d1, d2;

  function automatic logic [15:0] code(input logic [11:0] x, input logic [11:0] y);
    return {y[3:0], x};
  endfunction

  // Zero-latency sources for A and B, two-register latent source for C.
  assign pd_a = code(px_a, py_a);
  assign pd_b = code(px_b, py_b);
  always @(posedge clk) begin
    d1 <= code(px_c, py_c);
    d2 <= d1;
  end
  assign pd_c = d2;

  vga_timing_gen #(.BORDER_COLOR(32'hABCD)) u_a (
    .vga_clk(clk), .sys_rst(rst_a), .en(en_a), .pix_data(pd_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .pix_req(req_a), .pix_x(px_a), .pix_y(py_a),
    .rgb(rgb_a), .frame_start(fs_a), .line_start(ls_a), .running(run_a));

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_LEFT(1), .H_VALID(4), .H_RIGHT(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_TOP(1), .V_VALID(3), .V_BOTTOM(1), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BORDER_COLOR(32'h5A5A)
  ) u_b (
    .vga_clk(clk), .sys_rst(rst_b), .en(en_b), .pix_data(pd_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .pix_req(req_b), .pix_x(px_b), .pix_y(py_b),
    .rgb(rgb_b), .frame_start(fs_b), .line_start(ls_b), .running(run_b));

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_LEFT(2), .H_VALID(16), .H_RIGHT(2), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(6), .V_BOTTOM(1), .V_FRONT(2),
    .REQ_LEAD(3), .BORDER_COLOR(32'h0F0F)
  ) u_c (
    .vga_clk(clk), .sys_rst(rst_c), .en(en_c), .pix_data(pd_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .pix_req(req_c), .pix_x(px_c), .pix_y(py_c),
    .rgb(rgb_c), .frame_start(fs_c), .line_start(ls_c), .running(run_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string pfx, input logic hs, input logic vs, input logic de,
                          input logic req, input logic [11:0] px, input logic [11:0] py,
                          input logic [15:0] rgb, input logic fs, input logic ls,
                          input logic run, input logic hs_off, input logic vs_off);
    chk({pfx, "_hs"},  32'(hs),  32'(hs_off));
    chk({pfx, "_vs"},  32'(vs),  32'(vs_off));
    chk({pfx, "_de"},  32'(de),  32'h0);
    chk({pfx, "_req"}, 32'(req), 32'h0);
    chk({pfx, "_px"},  32'(px),  32'hFFF);
    chk({pfx, "_py"},  32'(py),  32'hFFF);
    chk({pfx, "_rgb"}, 32'(rgb), 32'h0);
    chk({pfx, "_fs"},  32'(fs),  32'h0);
    chk({pfx, "_ls"},  32'(ls),  32'h0);
    chk({pfx, "_run"}, 32'(run), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h, v;
    int hs_line0, vs_hi, de_l35, ls_n, fs_n, de_n, first_de, rise1, rise2;
    logic hs_prev, e_de, e_req;
    logic [9:0] hs_t, hde_t, hbd_t, hrq_t;
    logic [7:0] vs_t, vde_t, vbd_t;

    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0;
    tick(); tick();

    // ---------------- reset state ----------------
    chk_idle("a_rst", hs_a, vs_a, de_a, req_a, px_a, py_a, rgb_a, fs_a, ls_a, run_a, 1'b0, 1'b0);
    chk("b_rst_hs", 32'(hs_b), 32'h1);
    chk("b_rst_vs", 32'(vs_b), 32'h1);

    // ---------------- A: default timing, first 36 lines ----------------
    rst_a = 1'b0; en_a = 1'b1;
    tick();
    chk("a_run_rise", 32'(run_a), 32'h1);
    chk("a_fs_early", 32'(fs_a), 32'h0);
    hs_line0 = 0; vs_hi = 0; de_l35 = 0; ls_n = 0; fs_n = 0;
    first_de = -1; rise1 = -1; rise2 = -1; hs_prev = 1'b0;
    for (int p = 0; p < 36 * 800; p++) begin
      tick();
      h = p % 800; v = p / 800;
      if (v == 0 && hs_a) hs_line0++;
      if (vs_a) vs_hi++;
      if (v == 35 && de_a) de_l35++;
      if (ls_a) ls_n++;
      if (fs_a) fs_n++;
      if (de_a && first_de < 0) first_de = p;
      if (hs_a && !hs_prev) begin
        if (rise1 < 0) rise1 = p;
        else if (rise2 < 0) rise2 = p;
      end
      hs_prev = hs_a;
      if (p == 0) begin
        chk("a_fs_00", 32'(fs_a), 32'h1);
        chk("a_ls_00", 32'(ls_a), 32'h1);
        chk("a_hs_00", 32'(hs_a), 32'h1);
        chk("a_vs_00", 32'(vs_a), 32'h1);
      end
      if (p == 35 * 800 + 100) begin
        chk("a_rgb_100_35", 32'(rgb_a), 32'h0);
        chk("a_de_100_35",  32'(de_a),  32'h0);
      end
      if (p == 35 * 800 + 136) chk("a_rgb_136_35", 32'(rgb_a), 32'hABCD);
      if (p == 35 * 800 + 142) begin
        chk("a_req_142", 32'(req_a), 32'h0);
        chk("a_px_142",  32'(px_a),  32'hFFF);
      end
      if (p == 35 * 800 + 143) begin
        chk("a_req_143", 32'(req_a), 32'h1);
        chk("a_px_143",  32'(px_a),  32'h0);
        chk("a_py_143",  32'(py_a),  32'h0);
        chk("a_de_143",  32'(de_a),  32'h0);
      end
      if (p == 35 * 800 + 145) chk("a_rgb_145_35", 32'(rgb_a), 32'h0001);
      if (p == 35 * 800 + 783) begin
        chk("a_de_783",  32'(de_a),  32'h1);
        chk("a_rgb_783", 32'(rgb_a), 32'h027F);
      end
      if (p == 35 * 800 + 784) begin
        chk("a_de_784",  32'(de_a),  32'h0);
        chk("a_rgb_784", 32'(rgb_a), 32'hABCD);
        chk("a_req_784", 32'(req_a), 32'h0);
      end
    end
    chk("a_hs_width",   32'(hs_line0),      32'd96);
    chk("a_hs_period",  32'(rise2 - rise1), 32'd800);
    chk("a_vs_width",   32'(vs_hi),         32'd1600);
    chk("a_first_de",   32'(first_de),      32'(35 * 800 + 144));
    chk("a_de_line35",  32'(de_l35),        32'd640);
    chk("a_ls_count",   32'(ls_n),          32'd36);
    chk("a_fs_count",   32'(fs_n),          32'd1);
    en_a = 1'b0; rst_a = 1'b1;

    // ---------------- B: tiny mode, every position of a frame ----------------
    hs_t  = 10'b1111111100;  // active-low hsync for h<2
    vs_t  = 8'b11111110;     // active-low vsync for v<1
    hde_t = 10'b0011110000;  // h 4..7
    vde_t = 8'b00111000;     // v 3..5
    hbd_t = 10'b0111111000;  // h 3..8
    vbd_t = 8'b01111100;     // v 2..6
    hrq_t = 10'b0001111000;  // h+1 in 4..7
    rst_b = 1'b0; en_b = 1'b1;
    tick();
    chk("b_run_rise", 32'(run_b), 32'h1);
    for (int p = 0; p < 90; p++) begin
      tick();
      h = p % 10; v = (p / 10) % 8;
      e_de  = hde_t[4'(h)] & vde_t[3'(v)];
      e_req = hrq_t[4'(h)] & vde_t[3'(v)];
      chk("b_hs",  32'(hs_b),  32'(hs_t[4'(h)]));
      chk("b_vs",  32'(vs_b),  32'(vs_t[3'(v)]));
      chk("b_de",  32'(de_b),  32'(e_de));
      chk("b_req", 32'(req_b), 32'(e_req));
      chk("b_px",  32'(px_b),  e_req ? 32'(h - 3) : 32'hFFF);
      chk("b_py",  32'(py_b),  e_req ? 32'(v - 3) : 32'hFFF);
      chk("b_rgb", 32'(rgb_b),
          e_de ? 32'(code(12'(h - 4), 12'(v - 3)))
               : ((hbd_t[4'(h)] & vbd_t[3'(v)]) ? 32'h5A5A : 32'h0));
      chk("b_fs",  32'(fs_b),  32'(p % 80 == 0));
      chk("b_ls",  32'(ls_b),  32'(h == 0));
    end
    en_b = 1'b0; rst_b = 1'b1;

    // ---------------- C: REQ_LEAD=3 with latent source, then stop at frame end ----------------
    rst_c = 1'b0; en_c = 1'b1;
    tick();
    chk("c_run_rise", 32'(run_c), 32'h1);
    de_n = 0; fs_n = 0;
    for (int p = 0; p < 3 * 420; p++) begin
      tick();
      h = p % 30; v = (p / 30) % 14;
      if (fs_c) fs_n++;
      if (de_c) begin
        de_n++;
        chk("c_rgb", 32'(rgb_c), 32'(code(12'(h - 9), 12'(v - 5))));
      end
      if (p == 5 * 30 + 5) begin
        chk("c_req_pre", 32'(req_c), 32'h0);
        chk("c_px_pre",  32'(px_c),  32'hFFF);
      end
      if (p == 5 * 30 + 6) begin
        chk("c_req_first", 32'(req_c), 32'h1);
        chk("c_px_first",  32'(px_c),  32'h0);
        chk("c_py_first",  32'(py_c),  32'h0);
      end
      if (p == 5 * 30 + 21) begin
        chk("c_req_last", 32'(req_c), 32'h1);
        chk("c_px_last",  32'(px_c),  32'd15);
      end
      if (p == 5 * 30 + 22) begin
        chk("c_req_nowrap", 32'(req_c), 32'h0);
        chk("c_px_nowrap",  32'(px_c),  32'hFFF);
      end
      if (p == 840 + 7 * 30 + 15) en_c = 1'b0;
      if (p == 1258) chk("c_run_drain", 32'(run_c), 32'h1);
      if (p == 1259) chk("c_run_stop",  32'(run_c), 32'h0);
    end
    chk("c_de_count", 32'(de_n), 32'd288);
    chk("c_fs_count", 32'(fs_n), 32'd3);

    tick();
    chk_idle("c_idle", hs_c, vs_c, de_c, req_c, px_c, py_c, rgb_c, fs_c, ls_c, run_c, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_idle_fs",  32'(fs_c),  32'h0);
      chk("c_idle_run", 32'(run_c), 32'h0);
      chk("c_idle_hs",  32'(hs_c),  32'h0);
    end

    // Restart: running next cycle, frame_start one cycle after that.
    en_c = 1'b1;
    tick();
    chk("c_restart_run", 32'(run_c), 32'h1);
    chk("c_restart_fs0", 32'(fs_c),  32'h0);
    tick();
    chk("c_restart_fs",  32'(fs_c),  32'h1);
    chk("c_restart_hs",  32'(hs_c),  32'h1);
    chk("c_restart_ls",  32'(ls_c),  32'h1);

    // Mid-line reset at output position (20,8).
    for (int i = 0; i < 8 * 30 + 20; i++) tick();
    chk("c_pre_rst_de", 32'(de_c), 32'h1);
    rst_c = 1'b1;
    tick();
    chk_idle("c_rst", hs_c, vs_c, de_c, req_c, px_c, py_c, rgb_c, fs_c, ls_c, run_c, 1'b0, 1'b0);
    rst_c = 1'b0;
    tick();
    chk("c_post_rst_run", 32'(run_c), 32'h1);
    chk("c_post_rst_fs0", 32'(fs_c),  32'h0);
    tick();
    chk("c_post_rst_fs",  32'(fs_c),  32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
